// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared types and constants for the coherent scaler reader
package scaler_pkg;

  localparam int SCALER_HALF_W = 14;
  localparam int SCALER_W      = 28;

  localparam int DEF_SETTLE    = 2;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_H1,
    S_GAP1,
    S_RD_L,
    S_GAP2,
    S_RD_H2,
    S_GAP3,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/chan_strobe_gen.sv
// rtl/chan_strobe_gen.sv - SETTLE-cycle active-low read strobe for one of two channels
module chan_strobe_gen
  import scaler_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst_,
  input  logic start_i,
  input  logic sel_i,
  output logic rchat_o,
  output logic rchbt_o,
  output logic samp_o
);

  logic       act_q, act_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rchat_q, rchat_d;
  logic       rchbt_q, rchbt_d;

  always_comb begin
    act_d   = act_q;
    cnt_d   = cnt_q;
    rchat_d = rchat_q;
    rchbt_d = rchbt_q;
    if (start_i) begin
      act_d   = 1'b1;
      cnt_d   = 4'(SETTLE - 1);
      rchat_d = sel_i;
      rchbt_d = ~sel_i;
    end else if (act_q) begin
      if (cnt_q == 4'd0) begin
        act_d   = 1'b0;
        rchat_d = 1'b1;
        rchbt_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      act_q   <= 1'b0;
      cnt_q   <= 4'd0;
      rchat_q <= 1'b1;
      rchbt_q <= 1'b1;
    end else begin
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      rchat_q <= rchat_d;
      rchbt_q <= rchbt_d;
    end
  end

  // High during the last low cycle, so the consumer captures on the edge that releases the strobe.
  assign samp_o  = act_q && (cnt_q == 4'd0);
  assign rchat_o = rchat_q;
  assign rchbt_o = rchbt_q;

endmodule

// File: rtl/scaler_channel_reader.sv
// rtl/scaler_channel_reader.sv - coherent 28-bit scaler read via high/low/high channel reads
module scaler_channel_reader
  import scaler_pkg::*;
#(
  parameter int SETTLE    = DEF_SETTLE,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     req,
  output logic                     RCHAT_,
  output logic                     RCHBT_,
  input  logic [SCALER_HALF_W-1:0] CHAT,
  input  logic [SCALER_HALF_W-1:0] CHBT,
  output logic                     busy,
  output logic                     done,
  output logic [SCALER_W-1:0]      scaler,
  output logic                     err,
  output logic [2:0]               retries
);

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_e                   state_q;
  logic [SCALER_HALF_W-1:0] h1_q, l_q, h2_q;
  logic [2:0]               retry_q;
  logic                     busy_q, done_q, err_q;
  logic [SCALER_W-1:0]      scaler_q;
  logic [2:0]               retries_q;

  logic mismatch, retry_ok, strb_start, strb_sel, samp;

  assign mismatch = (h1_q != h2_q);
  assign retry_ok = (retry_q < MAX_R);

  // Strobes are launched on the edge that enters each RD state so the low window lines up with it.
  assign strb_start = ((state_q == S_IDLE) && req) || (state_q == S_GAP1) ||
                      (state_q == S_GAP2) || ((state_q == S_CHECK) && mismatch && retry_ok);
  assign strb_sel   = (state_q == S_GAP1);

  chan_strobe_gen #(
    .SETTLE(SETTLE)
  ) u_strobe (
    .clk    (clk),
    .rst_   (rst_),
    .start_i(strb_start),
    .sel_i  (strb_sel),
    .rchat_o(RCHAT_),
    .rchbt_o(RCHBT_),
    .samp_o (samp)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      h1_q      <= '0;
      l_q       <= '0;
      h2_q      <= '0;
      retry_q   <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      scaler_q  <= '0;
      retries_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          state_q <= S_RD_H1;
          retry_q <= 3'd0;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
        end
        S_RD_H1: if (samp) begin
          h1_q    <= CHAT;
          state_q <= S_GAP1;
        end
        S_GAP1: state_q <= S_RD_L;
        S_RD_L: if (samp) begin
          l_q     <= CHBT;
          state_q <= S_GAP2;
        end
        S_GAP2: state_q <= S_RD_H2;
        S_RD_H2: if (samp) begin
          h2_q    <= CHAT;
          state_q <= S_GAP3;
        end
        S_GAP3: state_q <= S_CHECK;
        S_CHECK: begin
          if (!mismatch) begin
            scaler_q  <= {h2_q, l_q};
            err_q     <= 1'b0;
            retries_q <= retry_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (retry_ok) begin
            retry_q <= retry_q + 3'd1;
            state_q <= S_RD_H1;
          end else begin
            err_q     <= 1'b1;
            retries_q <= retry_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign scaler  = scaler_q;
  assign retries = retries_q;

endmodule
